// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the CPU bus bridge: the bridge FSM state encoding
// and the default widths/depths that the CPU top also builds against.
package bus_bridge_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_WBUF_DEPTH = 4;
  localparam int unsigned DEF_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ISSUE = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_DONE  = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/bus_wbuf_fifo.sv
// Posted-write buffer for the CPU bus bridge. Holds {addr, wdata} entries
// in arrival order; the head entry stays in place while it is being issued
// downstream and is only removed by a pop. A push that arrives while full is
// accepted only if a pop happens on the same edge.
module bus_wbuf_fifo
  import bus_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int unsigned DEPTH = DEF_WBUF_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_level;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_level == CNT_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Entry storage needs no reset: the level counter decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= r_level + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/cpu_bus_bridge.sv
// Bridges the CPU strobe bus onto a single req/ack memory port. CPU writes
// are posted into a small FIFO; CPU reads wait until all buffered writes
// have drained, then issue and hold data-ready until the CPU drops its
// request. Every downstream access is bounded by a timeout counter, and
// dropped writes / timed-out accesses raise sticky flags.
module cpu_bus_bridge
  import bus_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned WBUF_DEPTH = DEF_WBUF_DEPTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wbuf_overflow,
  output logic              o_timeout,
  output logic              o_busy
);

  localparam int unsigned FIFO_W = ADDR_W + DATA_W;
  localparam int unsigned LVL_W  = $clog2(WBUF_DEPTH) + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT) + 1;

  bridge_state_t     r_state;
  logic              r_req_q;
  logic              r_rd_pending;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_wbuf_overflow;
  logic              r_timeout;
  logic              r_busy;

  logic              w_rise;
  logic              w_wr_edge;
  logic              w_rd_edge;
  logic              w_issue;
  logic              w_ack;
  logic              w_tmo_hit;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_rd_clear;
  logic              w_pend_next;
  logic              w_fifo_nonempty_next;
  logic [FIFO_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [LVL_W-1:0]  w_level;

  assign w_rise     = i_cpu_req & ~r_req_q;
  assign w_wr_edge  = w_rise & i_cpu_we;
  assign w_rd_edge  = w_rise & ~i_cpu_we & ~r_rd_pending;
  assign w_issue    = (r_state == ST_WR_ISSUE) | (r_state == ST_RD_ISSUE);
  assign w_ack      = w_issue & r_mem_req & i_mem_ack;
  assign w_tmo_hit  = w_issue & ~w_ack & (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign w_pop      = (r_state == ST_WR_ISSUE) & (w_ack | w_tmo_hit);
  assign w_push     = w_wr_edge & (~w_full | w_pop);
  assign w_drop     = w_wr_edge & w_full & ~w_pop;
  assign w_rd_clear = (r_state == ST_RD_DONE) & ~i_cpu_req;

  // An issuing write keeps its entry in the FIFO and an issuing/finished read
  // keeps read_pending set, so "FIFO non-empty or read pending" already
  // covers every in-flight access; busy is registered from their next values.
  assign w_pend_next          = (r_rd_pending & ~w_rd_clear) | w_rd_edge;
  assign w_fifo_nonempty_next = w_push |
                                (~w_empty & ~(w_pop & (w_level == LVL_W'(1))));

  assign o_mem_req       = r_mem_req;
  assign o_mem_we        = r_mem_we;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_cpu_ready     = r_cpu_ready;
  assign o_cpu_rdata     = r_cpu_rdata;
  assign o_wbuf_overflow = r_wbuf_overflow;
  assign o_timeout       = r_timeout;
  assign o_busy          = r_busy;

  bus_wbuf_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({i_cpu_addr, i_cpu_wdata}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Request edge detection, read capture, sticky flags and the busy summary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_q         <= 1'b0;
      r_rd_pending    <= 1'b0;
      r_rd_addr       <= '0;
      r_wbuf_overflow <= 1'b0;
      r_timeout       <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_req_q      <= i_cpu_req;
      r_rd_pending <= w_pend_next;
      if (w_rd_edge) begin
        r_rd_addr <= i_cpu_addr;
      end
      if (w_drop) begin
        r_wbuf_overflow <= 1'b1;
      end
      if (w_tmo_hit) begin
        r_timeout <= 1'b1;
      end
      r_busy <= w_fifo_nonempty_next | w_pend_next;
    end
  end

  // Access sequencer: drains writes before a pending read, always returning
  // through IDLE so o_mem_req drops for at least one cycle between accesses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tmo_cnt <= '0;
          if (!w_empty) begin
            r_state     <= ST_WR_ISSUE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_head[FIFO_W-1:DATA_W];
            r_mem_wdata <= w_head[DATA_W-1:0];
          end else if (r_rd_pending) begin
            r_state    <= ST_RD_ISSUE;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_rd_addr;
          end
        end
        ST_WR_ISSUE: begin
          if (w_ack || w_tmo_hit) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        ST_RD_ISSUE: begin
          if (w_ack) begin
            r_state     <= ST_RD_DONE;
            r_mem_req   <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= i_mem_rdata;
          end else if (w_tmo_hit) begin
            r_state     <= ST_RD_DONE;
            r_mem_req   <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= '1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        ST_RD_DONE: begin
          if (!i_cpu_req) begin
            r_state     <= ST_IDLE;
            r_cpu_ready <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
